pc_update_unit: RTL and testbench
=================================

PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2: number of cycles from vec_rd assertion to valid mem_data; legal range 1..15.
REQ-002 SHALL have parameter VECTOR_BASE, default 32'd253: byte address of the exception vector table.
REQ-003 SHALL have port clk, input, 1: single clock; every register updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port pc_next, input, 32: candidate PC from the PC-source mux.
REQ-006 SHALL have ports pc_write and pc_write_cond, input, 1 each: unconditional write and branch-conditional write.
REQ-007 SHALL have port branch_type, input, 2: 00 beq, 01 bne, 10 bgt, 11 ble.
REQ-008 SHALL have ports alu_zero and alu_gt, input, 1 each: ALU flags.
REQ-009 SHALL have ports exc_req (input, 1) and exc_cause (input, 2): exception pulse and its cause code.
REQ-010 SHALL have port mem_data, input, 8: handler address byte returned by memory.
REQ-011 SHALL have port pc, output, 32: architectural PC.
REQ-012 SHALL have port epc, output, 32: saved exception PC.
REQ-013 SHALL have port cause_q, output, 2: latched exception cause.
REQ-014 SHALL have ports exc_busy and vec_rd, output, 1 each: exception sequence active; vector read request.
REQ-015 SHALL have port vec_addr, output, 32: vector read address.

Function
REQ-016 SHALL compute branch_taken: beq = alu_zero; bne = !alu_zero; bgt = alu_gt; ble = !alu_gt.
REQ-017 SHALL, in IDLE, load pc <= pc_next when pc_write, or when pc_write_cond with branch_taken, with one-cycle latency.
REQ-018 SHALL implement FSM states IDLE, WAIT and LOAD.
REQ-019 SHALL, on exc_req in IDLE: transition to WAIT, set epc <= pc - 4 (modulo 2^32) and cause_q <= exc_cause, and not load pc_next that cycle; exceptions take priority over writes.
REQ-020 SHALL stay in WAIT for exactly MEM_LATENCY cycles, driving vec_rd = 1 and vec_addr = VECTOR_BASE + cause_q, using a 4-bit down-counter.
REQ-021 SHALL, in LOAD, set pc <= {24'b0, mem_data} and return to IDLE.
REQ-022 SHALL drive exc_busy = 1 in WAIT and LOAD, and 0 in IDLE.
REQ-023 SHALL ignore pc_write, pc_write_cond and exc_req while exc_busy = 1.
REQ-024 SHALL drive vec_rd = 0 and vec_addr = 0 outside WAIT.
REQ-025 SHALL leave epc and cause_q unchanged except on the IDLE exc_req capture.

Reset
REQ-026 SHALL, while rst_n = 0 (asynchronously, including mid-sequence), force: state IDLE; pc, epc and counter 0; cause_q 0; exc_busy, vec_rd and vec_addr 0.
REQ-027 SHALL, on the first edge after rst_n deasserts, behave as IDLE with pc = 0.

Configuration
REQ-028 SHALL support macro PC_ALIGN_CHECK_EN. When defined, an accepted IDLE write with pc_next[1:0] != 0 SHALL NOT update pc and SHALL start the exception sequence with cause 2'b10. When undefined, pc_next SHALL be loaded unchecked.

Structure
REQ-029 SHALL place branch_type codes, cause codes and the FSM state encoding in shared package pc_pkg.
REQ-030 SHALL implement branch evaluation as combinational sub-module pc_branch_cond, instantiated once.

Verification
REQ-031 SHALL verify: pc_write = 1, pc_next = 32'h40 -> pc = 32'h40 one cycle later.
REQ-032 SHALL verify: pc_write_cond = 1, branch_type = 01, alu_zero = 1, pc_next = 32'h80 -> pc unchanged; with alu_zero = 0 -> pc = 32'h80.
REQ-033 SHALL verify, with MEM_LATENCY = 2: pc = 32'h104, exc_req with cause 01 at cycle 0 -> epc = 32'h100, cause_q = 01; vec_rd high in cycles 1-2 with vec_addr = 254; mem_data = 8'h9C -> pc = 32'h9C at cycle 4; exc_busy low at cycle 4.
REQ-034 SHALL verify: exc_req and pc_write in the same cycle -> pc_next discarded; exc_req during WAIT -> ignored, epc unchanged.
REQ-035 SHALL verify: rst_n pulsed low during WAIT -> all outputs 0 immediately, IDLE after release.
REQ-036 SHALL verify, with PC_ALIGN_CHECK_EN defined: pc_write with pc_next = 32'h42 -> pc unchanged, cause_q = 10, exc_busy = 1 next cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the PC update unit: branch types, exception causes, FSM states.
package pc_pkg;

   typedef enum logic [1:0] {
      BR_BEQ = 2'b00,
      BR_BNE = 2'b01,
      BR_BGT = 2'b10,
      BR_BLE = 2'b11
   } branch_t;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_LOAD = 2'b10
   } state_t;

endpackage

// File: rtl/pc_branch_cond.sv
// Combinational branch condition evaluation from ALU flags.
module pc_branch_cond
   import pc_pkg::*;
(
   input  logic [1:0] branch_type,
   input  logic       alu_zero,
   input  logic       alu_gt,
   output logic       branch_taken
);

   always_comb begin
      branch_taken = 1'b0;
      case (branch_t'(branch_type))
         BR_BEQ:  branch_taken = alu_zero;
         BR_BNE:  branch_taken = !alu_zero;
         BR_BGT:  branch_taken = alu_gt;
         BR_BLE:  branch_taken = !alu_gt;
         default: branch_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_update_unit.sv
// PC register with branch-conditional writes and a vectored exception sequence.
// Optional macro PC_ALIGN_CHECK_EN: misaligned accepted writes raise a cause-10 exception.
//
// state | meaning
// IDLE  | normal operation, PC writes and exception capture accepted
// WAIT  | vector read outstanding for MEM_LATENCY cycles
// LOAD  | handler address byte loaded into pc
module pc_update_unit
   import pc_pkg::*;
#(
   parameter int          MEM_LATENCY = 2,
   parameter logic [31:0] VECTOR_BASE = 32'd253
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_next,
   input  logic        pc_write,
   input  logic        pc_write_cond,
   input  logic [1:0]  branch_type,
   input  logic        alu_zero,
   input  logic        alu_gt,
   input  logic        exc_req,
   input  logic [1:0]  exc_cause,
   input  logic [7:0]  mem_data,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic [1:0]  cause_q,
   output logic        exc_busy,
   output logic        vec_rd,
   output logic [31:0] vec_addr
);

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t      state_q, state_d;
   logic [31:0] pc_d, epc_d;
   logic [1:0]  cause_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        branch_taken;
   logic        wr_acc;
   logic        misalign;

   pc_branch_cond u_branch_cond (
      .branch_type  (branch_type),
      .alu_zero     (alu_zero),
      .alu_gt       (alu_gt),
      .branch_taken (branch_taken)
   );

   assign wr_acc = pc_write | (pc_write_cond & branch_taken);

`ifdef PC_ALIGN_CHECK_EN
   assign misalign = (pc_next[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc      <= '0;
         epc     <= '0;
         cause_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc      <= pc_d;
         epc     <= epc_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc;
      epc_d    = epc;
      cause_d  = cause_q;
      cnt_d    = cnt_q;
      exc_busy = 1'b0;
      vec_rd   = 1'b0;
      vec_addr = '0;
      case (state_q)
         ST_IDLE: begin
            // Exceptions win over any write in the same cycle.
            if (exc_req) begin
               state_d = ST_WAIT;
               epc_d   = pc - 32'd4;
               cause_d = exc_cause;
               cnt_d   = CNT_INIT;
            end else if (wr_acc) begin
               if (misalign) begin
                  state_d = ST_WAIT;
                  epc_d   = pc - 32'd4;
                  cause_d = CAUSE_MISALIGN;
                  cnt_d   = CNT_INIT;
               end else begin
                  pc_d = pc_next;
               end
            end
         end
         ST_WAIT: begin
            exc_busy = 1'b1;
            vec_rd   = 1'b1;
            vec_addr = VECTOR_BASE + {30'b0, cause_q};
            if (cnt_q == 4'd0) state_d = ST_LOAD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_LOAD: begin
            exc_busy = 1'b1;
            pc_d     = {24'b0, mem_data};
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed scenarios then randomized traffic vs. a phase-count model.
module tb_pc_update_unit;

   localparam int          LAT  = 2;
   localparam logic [31:0] BASE = 32'd253;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_next;
   logic        pc_write, pc_write_cond;
   logic [1:0]  branch_type;
   logic        alu_zero, alu_gt;
   logic        exc_req;
   logic [1:0]  exc_cause;
   logic [7:0]  mem_data;
   logic [31:0] pc, epc, vec_addr;
   logic [1:0]  cause_q;
   logic        exc_busy, vec_rd;

   int checks = 0;
   int errors = 0;

   // Model: m_ph = 0 when idle, else number of cycles since the exception was captured.
   logic [31:0] m_pc, m_epc;
   logic [1:0]  m_cause;
   int          m_ph;

   pc_update_unit #(.MEM_LATENCY(LAT), .VECTOR_BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .branch_type(branch_type),
      .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_req(exc_req),
      .exc_cause(exc_cause), .mem_data(mem_data), .pc(pc), .epc(epc),
      .cause_q(cause_q), .exc_busy(exc_busy), .vec_rd(vec_rd), .vec_addr(vec_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic exp_rd;
      exp_rd = (m_ph >= 1) && (m_ph <= LAT);
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("cause_q", 32'(cause_q), 32'(m_cause));
      chk("exc_busy", 32'(exc_busy), 32'(m_ph != 0));
      chk("vec_rd", 32'(vec_rd), 32'(exp_rd));
      chk("vec_addr", vec_addr, exp_rd ? BASE + 32'(m_cause) : 32'd0);
   endtask

   task automatic model_edge();
      logic taken;
      if (m_ph != 0) begin
         if (m_ph == LAT + 1) begin
            m_pc = {24'b0, mem_data};
            m_ph = 0;
         end else begin
            m_ph++;
         end
      end else begin
         case (branch_type)
            2'd0: taken = alu_zero;
            2'd1: taken = !alu_zero;
            2'd2: taken = alu_gt;
            default: taken = !alu_gt;
         endcase
         if (exc_req) begin
            m_epc = m_pc - 32'd4; m_cause = exc_cause; m_ph = 1;
         end else if (pc_write || (pc_write_cond && taken)) begin
`ifdef PC_ALIGN_CHECK_EN
            if (pc_next[1:0] != 2'b00) begin
               m_epc = m_pc - 32'd4; m_cause = 2'b10; m_ph = 1;
            end else m_pc = pc_next;
`else
            m_pc = pc_next;
`endif
         end
      end
   endtask

   task automatic model_reset();
      m_pc = '0; m_epc = '0; m_cause = '0; m_ph = 0;
   endtask

   task automatic clr_in();
      pc_next = '0; pc_write = 0; pc_write_cond = 0; branch_type = '0;
      alu_zero = 0; alu_gt = 0; exc_req = 0; exc_cause = '0;
   endtask

   // Inputs are set on the falling edge; model advances with them, then DUT is sampled a falling edge later.
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   initial begin
      rst_n = 0; mem_data = '0;
      clr_in();
      model_reset();
      repeat (2) @(negedge clk);
      check_model();
      rst_n = 1;
      step();
      chk("reset_pc", pc, 32'd0);

      // Unconditional write.
      pc_write = 1; pc_next = 32'h40;
      step();
      chk("wr_pc40", pc, 32'h40);

      // bne not taken, then taken.
      clr_in(); pc_write_cond = 1; branch_type = 2'b01; alu_zero = 1; pc_next = 32'h80;
      step();
      chk("bne_nt", pc, 32'h40);
      alu_zero = 0;
      step();
      chk("bne_t", pc, 32'h80);

      // Exception sequence with handler byte 0x9C.
      clr_in(); pc_write = 1; pc_next = 32'h104;
      step();
      clr_in(); exc_req = 1; exc_cause = 2'b01; mem_data = 8'h9C;
      step();
      chk("exc_epc", epc, 32'h100);
      chk("exc_cause", 32'(cause_q), 32'd1);
      chk("c1_vec_rd", 32'(vec_rd), 32'd1);
      chk("c1_vec_addr", vec_addr, 32'd254);
      clr_in();
      step();
      chk("c2_vec_rd", 32'(vec_rd), 32'd1);
      step();
      chk("c3_vec_rd", 32'(vec_rd), 32'd0);
      chk("c3_busy", 32'(exc_busy), 32'd1);
      step();
      chk("c4_pc", pc, 32'h9C);
      chk("c4_busy", 32'(exc_busy), 32'd0);

      // Exception with simultaneous write; second exception in WAIT ignored.
      exc_req = 1; exc_cause = 2'b11; pc_write = 1; pc_next = 32'h500; mem_data = 8'h33;
      step();
      chk("exc_wr_pc", pc, 32'h9C);
      chk("exc_wr_epc", epc, 32'h98);
      exc_cause = 2'b00; pc_write = 1; pc_next = 32'h600;
      step();
      chk("wait_epc", epc, 32'h98);
      chk("wait_cause", 32'(cause_q), 32'd3);
      clr_in();
      repeat (2) step();
      chk("ret_pc", pc, 32'h33);

      // Reset asserted in the middle of WAIT.
      exc_req = 1; exc_cause = 2'b10;
      step();
      clr_in();
      rst_n = 0;
      #1;
      model_reset();
      chk("rst_pc", pc, 32'd0);
      chk("rst_epc", epc, 32'd0);
      chk("rst_cause", 32'(cause_q), 32'd0);
      chk("rst_busy", 32'(exc_busy), 32'd0);
      chk("rst_vec_rd", 32'(vec_rd), 32'd0);
      chk("rst_vec_addr", vec_addr, 32'd0);
      @(negedge clk);
      rst_n = 1;
      step();
      chk("post_rst_busy", 32'(exc_busy), 32'd0);

      // Misaligned write handling.
      pc_write = 1; pc_next = 32'h42; mem_data = 8'h10;
      step();
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_pc", pc, 32'd0);
      chk("mis_cause", 32'(cause_q), 32'd2);
      chk("mis_busy", 32'(exc_busy), 32'd1);
`else
      chk("mis_pc", pc, 32'h42);
`endif
      clr_in();
      repeat (LAT + 2) step();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         pc_write      = ($urandom_range(3) == 0);
         pc_write_cond = ($urandom_range(3) == 0);
         branch_type   = 2'($urandom_range(3));
         alu_zero      = 1'($urandom_range(1));
         alu_gt        = 1'($urandom_range(1));
         exc_req       = ($urandom_range(7) == 0);
         exc_cause     = 2'($urandom_range(3));
         mem_data      = 8'($urandom);
         pc_next       = $urandom;
         if ($urandom_range(3) != 0) pc_next[1:0] = 2'b00;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
